if_fetch: RTL

- Instruction-fetch stage of the 5-stage RV32I pipeline; sits directly upstream of the decode stage.
- Fetches 32-bit instructions over the shared byte-wide memory port, four bytes, little-endian, and assembles them.
- Presents {pc+4, instruction} to the IF/ID boundary.
- Accepts redirects from decode (jump/branch target) and stalls from the hazard logic.
- Emits instruction 32'h0 as a bubble; decode treats 32'h0 as a NOP.

---
 rtl/if_fetch.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the 5-stage RV32I pipeline.
// Fetches one 32-bit little-endian instruction as four byte reads over the
// shared byte-wide memory port, then presents {pc+4, instruction} to IF/ID.
// Redirects from decode override everything except reset; 32'h0 is a bubble.
//
// Optional feature: define IF_ICACHE_EN to add a 16-entry direct-mapped word
// cache (index pc[5:2], tag pc[ADDR_W-1:6]) that skips the byte sequence on a hit.

module if_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_en,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              mem_gnt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_din,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_is
);

    typedef enum logic [2:0] {
        StF0   = 3'd0,
        StF1   = 3'd1,
        StF2   = 3'd2,
        StF3   = 3'd3,
        StWait = 3'd4,
        StHold = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic              pend_q, pend_d;
    logic [1:0]        pidx_q, pidx_d;
    logic [31:0]       buf_q, buf_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic [31:0]       out_is_q, out_is_d;
    logic              req_c;
    logic [1:0]        byte_idx;

    assign pc_plus4 = pc_q + ADDR_W'(4);

`ifdef IF_ICACHE_EN
    localparam int unsigned TagW = ADDR_W - 6;

    logic [15:0]     cv_q, cv_d;
    logic [TagW-1:0] ctag_q [16];
    logic [31:0]     cdata_q [16];
    logic [3:0]      cidx;
    logic [TagW-1:0] ctag;
    logic            cache_hit;
    logic            cache_we;

    assign cidx      = pc_q[5:2];
    assign ctag      = pc_q[ADDR_W-1:6];
    assign cache_hit = cv_q[cidx] && (ctag_q[cidx] == ctag);

    // Mark the filled entry valid; only valid bits are reset so rst leaves the cache cold.
    always_comb begin
        cv_d = cv_q;
        if (cache_we) begin
            cv_d[cidx] = 1'b1;
        end
    end

    // Cache valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cv_q <= '0;
        end else begin
            cv_q <= cv_d;
        end
    end

    // Cache tag/data storage; buf_d already holds the byte captured during WAIT.
    always_ff @(posedge clk) begin
        if (cache_we) begin
            ctag_q[cidx]  <= ctag;
            cdata_q[cidx] <= buf_d;
        end
    end
`endif

    // Next-state, capture, output-register and memory-request logic.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = 1'b0;
        pidx_d      = pidx_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_is_d    = out_is_q;
        req_c       = 1'b0;
        byte_idx    = 2'd0;
`ifdef IF_ICACHE_EN
        cache_we    = 1'b0;
`endif

        // A byte granted last cycle lands now, whatever state we are in.
        if (pend_q) begin
            buf_d[8*pidx_q +: 8] = mem_din;
        end

        unique case (state_q)
            StF0: begin
`ifdef IF_ICACHE_EN
                if (cache_hit) begin
                    out_valid_d = 1'b1;
                    out_is_d    = cdata_q[cidx];
                    out_pc_d    = pc_plus4;
                    pc_d        = pc_plus4;
                    state_d     = StHold;
                end else
`endif
                begin
                    req_c    = 1'b1;
                    byte_idx = 2'd0;
                    if (mem_gnt) begin
                        pend_d  = 1'b1;
                        pidx_d  = 2'd0;
                        state_d = StF1;
                    end
                end
            end
            StF1: begin
                req_c    = 1'b1;
                byte_idx = 2'd1;
                if (mem_gnt) begin
                    pend_d  = 1'b1;
                    pidx_d  = 2'd1;
                    state_d = StF2;
                end
            end
            StF2: begin
                req_c    = 1'b1;
                byte_idx = 2'd2;
                if (mem_gnt) begin
                    pend_d  = 1'b1;
                    pidx_d  = 2'd2;
                    state_d = StF3;
                end
            end
            StF3: begin
                req_c    = 1'b1;
                byte_idx = 2'd3;
                if (mem_gnt) begin
                    pend_d  = 1'b1;
                    pidx_d  = 2'd3;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Byte 3 arrives this cycle, so assemble from buf_d rather than buf_q.
                out_valid_d = 1'b1;
                out_is_d    = buf_d;
                out_pc_d    = pc_plus4;
                pc_d        = pc_plus4;
                state_d     = StHold;
`ifdef IF_ICACHE_EN
                cache_we    = 1'b1;
`endif
            end
            StHold: begin
                if (!stall) begin
                    out_valid_d = 1'b0;
                    out_is_d    = '0;
                    out_pc_d    = '0;
                    state_d     = StF0;
                end
            end
            default: begin
                state_d = StF0;
            end
        endcase

        // Redirect beats stall and every state; any byte in flight is dropped.
        if (br_en) begin
            pc_d        = br_target;
            state_d     = StF0;
            pend_d      = 1'b0;
            out_valid_d = 1'b0;
            out_is_d    = '0;
            out_pc_d    = '0;
`ifdef IF_ICACHE_EN
            cache_we    = 1'b0;
`endif
        end
    end

    // Pipeline state and output register; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StF0;
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pidx_q      <= 2'd0;
            buf_q       <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_is_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pidx_q      <= pidx_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_is_q    <= out_is_d;
        end
    end

    // Memory request is combinational from state/pc, forced idle while rst is held.
    assign mem_req  = req_c && !rst;
    assign mem_addr = (req_c && !rst) ? (pc_q + ADDR_W'(byte_idx)) : '0;

    assign if_valid = out_valid_q;
    assign if_pc    = out_pc_q;
    assign if_is    = out_is_q;

endmodule
